// File: rtl/operand_handler_pipe_if.sv
// Operand request/response bundle between the ID stage and the operand handler.
interface operand_handler_pipe_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned IMM_W   = 16,
    parameter int unsigned SHAMT_W = 5
);
    logic                 in_valid;
    logic                 stall;
    logic                 flush;
    logic [3:0]           Si;
    logic [WIDTH-1:0]     PB;
    logic [WIDTH-1:0]     PC;
    logic [IMM_W-1:0]     imm;
    logic [SHAMT_W-1:0]   shamt;
    logic                 hi_we;
    logic                 lo_we;
    logic [WIDTH-1:0]     hi_wdata;
    logic [WIDTH-1:0]     lo_wdata;
    logic                 hilo_we;
    logic [2*WIDTH-1:0]   hilo_wdata;
    logic [WIDTH-1:0]     N;
    logic                 out_valid;
    logic [WIDTH-1:0]     HI_q;
    logic [WIDTH-1:0]     LO_q;

    modport master (
        output in_valid, stall, flush, Si, PB, PC, imm, shamt,
               hi_we, lo_we, hi_wdata, lo_wdata, hilo_we, hilo_wdata,
        input  N, out_valid, HI_q, LO_q
    );

    modport slave (
        input  in_valid, stall, flush, Si, PB, PC, imm, shamt,
               hi_we, lo_we, hi_wdata, lo_wdata, hilo_we, hilo_wdata,
        output N, out_valid, HI_q, LO_q
    );
endinterface

// File: rtl/operand_handler_pipe.sv
// ALU B-operand selector with registered output and internal HI/LO pair.
// HI/LO reads through Si=1/2 bypass same-cycle writes, so no RAW bubbles.
// WIDTH must be at least 2*IMM_W.
module operand_handler_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned IMM_W   = 16,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    operand_handler_pipe_if.slave  bus
);
    localparam int unsigned EXT_W = WIDTH - IMM_W;

    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH-1:0] operand_c;

    // Resolve pending HI/LO writes; the mult/div result wins over mthi/mtlo.
    always_comb begin
        hi_next = bus.HI_q;
        lo_next = bus.LO_q;
        if (bus.hilo_we) begin
            hi_next = bus.hilo_wdata[2*WIDTH-1:WIDTH];
            lo_next = bus.hilo_wdata[WIDTH-1:0];
        end else begin
            if (bus.hi_we) begin
                hi_next = bus.hi_wdata;
            end
            if (bus.lo_we) begin
                lo_next = bus.lo_wdata;
            end
        end
    end

    // Operand select decode.
    always_comb begin
        operand_c = '0;
        case (bus.Si)
            4'd0:    operand_c = bus.PB;
            4'd1:    operand_c = hi_next;
            4'd2:    operand_c = lo_next;
            4'd3:    operand_c = bus.PC;
            4'd4:    operand_c = {{EXT_W{bus.imm[IMM_W-1]}}, bus.imm};
            4'd5:    operand_c = {bus.imm, {EXT_W{1'b0}}};
            4'd6:    operand_c = WIDTH'(bus.imm);
            4'd7:    operand_c = bus.PC + WIDTH'(8);
            4'd8:    operand_c = WIDTH'(bus.shamt);
            default: operand_c = '0;
        endcase
    end

    // HI/LO pair: updates every edge regardless of stall/flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.HI_q <= '0;
            bus.LO_q <= '0;
        end else begin
            bus.HI_q <= hi_next;
            bus.LO_q <= lo_next;
        end
    end

    // Output register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.N         <= '0;
            bus.out_valid <= 1'b0;
        end else if (bus.flush) begin
            bus.N         <= '0;
            bus.out_valid <= 1'b0;
        end else if (!bus.stall) begin
            bus.N         <= operand_c;
            bus.out_valid <= bus.in_valid;
        end
    end
endmodule

// File: doc/operand_handler_pipe.md
# operand_handler_pipe

Registered, parametrised second-operand selector for the MIPS datapath's ID/EX boundary. It selects the ALU B-operand (N) and registers it with a valid bit, stall and flush control. The HI/LO register pair lives inside the block, with write ports for mthi/mtlo and for the 64-bit mult/div result. A same-cycle write/read bypass means a HI/LO read never returns stale data.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be ≥ 2·IMM_W.
- IMM_W, 16, immediate field width.
- SHAMT_W, 5, shift-amount field width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operand request is valid this cycle.
- stall  input  1  hold the output register.
- flush  input  1  kill the output register contents.
- Si  input  4  operand select.
- PB  input  WIDTH  register-file port B.
- PC  input  WIDTH  instruction address.
- imm  input  IMM_W  immediate field.
- shamt  input  SHAMT_W  shift-amount field.
- hi_we  input  1  mthi write enable.
- lo_we  input  1  mtlo write enable.
- hi_wdata  input  WIDTH  mthi data.
- lo_wdata  input  WIDTH  mtlo data.
- hilo_we  input  1  mult/div result write enable.
- hilo_wdata  input  2·WIDTH  mult/div result; upper half goes to HI, lower half to LO.
- N  output  WIDTH  registered operand.
- out_valid  output  1  N holds a live operand.
- HI_q  output  WIDTH  current HI register.
- LO_q  output  WIDTH  current LO register.

## Operation
- Select decode (Si → next operand):
  - 0 → PB
  - 1 → HI_next
  - 2 → LO_next
  - 3 → PC
  - 4 → sign-extended imm
  - 5 → {imm, (WIDTH−IMM_W) zeros} (lui)
  - 6 → zero-extended imm
  - 7 → PC+8, mod 2^WIDTH (link address)
  - 8 → zero-extended shamt
  - 9–15 → 0
- HI_next / LO_next resolve pending writes in this order:
  - hilo_we=1: HI_next = hilo_wdata upper half, LO_next = hilo_wdata lower half.
  - hilo_we=0, hi_we=1: HI_next = hi_wdata.
  - hilo_we=0, lo_we=1: LO_next = lo_wdata.
  - Otherwise HI_next = HI_q and LO_next = LO_q.
  - hilo_we has priority over hi_we/lo_we when asserted together.
- HI/LO update:
  - Every clock edge, HI_q←HI_next and LO_q←LO_next.
  - stall and flush have no effect on HI/LO writes; writeback comes from a later stage.
- Output register, priority reset > flush > stall > load:
  - reset: N=0, out_valid=0, HI_q=0, LO_q=0.
  - flush: N=0, out_valid=0. Flush beats stall.
  - stall (no flush): N and out_valid hold.
  - otherwise: N←selected operand, out_valid←in_valid. N loads even when in_valid=0; consumers qualify on out_valid.

## Timing
- Latency is 1 cycle from Si and the data inputs to N.
- Bypass: a HI/LO write in cycle t is visible through Si=1 or Si=2 in N at edge t+1, the same edge at which HI_q/LO_q update. There are no read-after-write bubbles.
- When stall is released, the next edge loads whatever inputs are present then. Upstream must hold its inputs during a stall.
- Reset mid-operation clears everything at the next edge, with no partial state. A write presented in the same cycle as reset is dropped.
- PC+8 wraps: PC=0xFFFFFFFC gives 0x00000004.

## Test plan
- Reset, then Si=0, PB=0x12345678, in_valid=1 → one cycle later N=0x12345678, out_valid=1. During reset, N=0, out_valid=0, HI_q=LO_q=0.
- Immediate modes with imm=0x8001:
  - Si=4 → 0xFFFF8001
  - Si=5 → 0x80010000
  - Si=6 → 0x00008001
  - Si=8 with shamt=31 → 0x0000001F
  - Si=12 → 0
- Bypass and priority:
  - hilo_we=1 with hilo_wdata=0xAAAA0000_BBBB1111, Si=1 in the same cycle → next N=0xAAAA0000; HI_q=0xAAAA0000 and LO_q=0xBBBB1111.
  - Same cycle plus hi_we=1 with hi_wdata=0x5 → HI_q=0xAAAA0000 (hilo_we wins).
- Stall/flush:
  - Load N=0x11, then stall=1 for 3 cycles while PB changes → N stays 0x11.
  - Assert flush and stall together → N=0, out_valid=0.
  - Meanwhile lo_we=1 with lo_wdata=0x7 → LO_q=0x7 despite the stall.
- PC modes:
  - Si=7, PC=0xFFFFFFFC → N=0x00000004.
  - Si=3 → N=PC.
  - in_valid=0 → out_valid=0 while N still loads.
- Assert reset in the middle of a stalled, valid operand → next edge N=0, out_valid=0, HI_q=LO_q=0. A hi_we presented in the same cycle is discarded.
